// File: rtl/vortex_launch_ctrl.sv
// Kernel-launch sequencer: replays a small DCR table into Vortex, waits for
// the core to go busy and then idle, and reports one completion record.
module vortex_launch_ctrl #(
  parameter int DCR_ADDR_WIDTH = 8,
  parameter int DCR_DATA_WIDTH = 32,
  parameter int NUM_CFG        = 4,
  parameter int START_WAIT     = 64,
  parameter int CNT_WIDTH      = 32,
  localparam int IDXW          = $clog2(NUM_CFG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr_valid,
  input  logic [IDXW-1:0]           cfg_wr_idx,
  input  logic [DCR_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [DCR_DATA_WIDTH-1:0] cfg_wr_data,
  output logic                      cfg_wr_rdy,
  input  logic                      cfg_clr,
  input  logic                      start_valid,
  output logic                      start_rdy,
  input  logic [CNT_WIDTH-1:0]      timeout_limit,
  output logic                      dcr_wr_valid,
  output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
  input  logic                      vx_busy,
  output logic                      done_valid,
  output logic [1:0]                done_status,
  output logic [CNT_WIDTH-1:0]      done_cycles,
  input  logic                      done_rdy,
  output logic                      ctrl_busy
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SETTLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_NOSTART = 2'd2;
  localparam logic [1:0] ST_EMPTY   = 2'd3;

  localparam logic [IDXW-1:0]      IDX_LAST  = IDXW'(NUM_CFG - 1);
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(START_WAIT - 1);

  state_t state, state_n;

  logic [NUM_CFG-1:0]                     tbl_vld, tbl_vld_n;
  logic [NUM_CFG-1:0][DCR_ADDR_WIDTH-1:0] tbl_addr, tbl_addr_n;
  logic [NUM_CFG-1:0][DCR_DATA_WIDTH-1:0] tbl_data, tbl_data_n;

  logic [IDXW-1:0]      idx, idx_n;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [1:0]           status_n;

  assign cfg_wr_rdy  = (state == S_IDLE);
  assign start_rdy   = (state == S_IDLE) && !vx_busy;
  assign ctrl_busy   = (state != S_IDLE);
  assign done_valid  = (state == S_DONE);
  // The counter freezes in DONE, so it doubles as the reported cycle count.
  assign done_cycles = cycle_cnt;

  // Table view after this cycle's update: clear first, then the write.
  always_comb begin
    tbl_vld_n  = tbl_vld;
    tbl_addr_n = tbl_addr;
    tbl_data_n = tbl_data;
    if (state == S_IDLE) begin
      if (cfg_clr) tbl_vld_n = '0;
      if (cfg_wr_valid) begin
        tbl_vld_n[cfg_wr_idx]  = 1'b1;
        tbl_addr_n[cfg_wr_idx] = cfg_wr_addr;
        tbl_data_n[cfg_wr_idx] = cfg_wr_data;
      end
    end
  end

  // Next-state, write pointer and completion status.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    status_n = done_status;
    case (state)
      S_IDLE: begin
        if (start_valid && start_rdy) begin
          idx_n = '0;
          if (|tbl_vld_n) begin
            state_n = S_WRITE;
          end else begin
            state_n  = S_DONE;
            status_n = ST_EMPTY;
          end
        end
      end
      S_WRITE: begin
        idx_n = idx + IDXW'(1);
        if (idx == IDX_LAST) state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (vx_busy) begin
          state_n = S_RUN;
        end else if (cycle_cnt == WAIT_LAST) begin
          state_n  = S_DONE;
          status_n = ST_NOSTART;
        end
      end
      S_RUN: begin
        // Busy falling takes priority over a coincident timeout.
        if (!vx_busy) begin
          state_n  = S_DONE;
          status_n = ST_OK;
        end else if (timeout_limit != '0 &&
                     cycle_cnt == timeout_limit - CNT_WIDTH'(1)) begin
          state_n  = S_DONE;
          status_n = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        if (done_rdy) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, pointer, status and table registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      done_status <= '0;
      tbl_vld     <= '0;
      tbl_addr    <= '0;
      tbl_data    <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      done_status <= status_n;
      tbl_vld     <= tbl_vld_n;
      tbl_addr    <= tbl_addr_n;
      tbl_data    <= tbl_data_n;
    end
  end

  // DCR strobe is registered off the next state so entry k appears at T+1+k.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
    end else if (state_n == S_WRITE && tbl_vld_n[idx_n]) begin
      dcr_wr_valid <= 1'b1;
      dcr_wr_addr  <= tbl_addr_n[idx_n];
      dcr_wr_data  <= tbl_data_n[idx_n];
    end else begin
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
    end
  end

  // Saturating SETTLE+RUN cycle counter; held in DONE, zero elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state == S_SETTLE || state == S_RUN) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end else if (state != S_DONE) begin
      cycle_cnt <= '0;
    end
  end

endmodule

// File: doc/vortex_launch_ctrl.md
Name: vortex_launch_ctrl

Overview:
- Kernel-launch sequencer on the Vortex clock domain, sitting between the DCR buffer path and the Vortex DCR write port.
- Holds a small table of DCR (addr, data) entries loaded by the NoC-side control.
- On a start request it replays the valid entries into Vortex as DCR writes, then watches the Vortex busy status.
- Returns one completion record per launch: status plus elapsed cycle count.

Parameters:
- DCR_ADDR_WIDTH, 8, DCR address width
- DCR_DATA_WIDTH, 32, DCR data width
- NUM_CFG, 4, table entries (power of 2, >=2); IDXW = $clog2(NUM_CFG)
- START_WAIT, 64, max cycles in SETTLE waiting for busy to rise
- CNT_WIDTH, 32, cycle counter / timeout width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_wr_valid  in  1  table write request
- cfg_wr_idx  in  IDXW  table entry index
- cfg_wr_addr  in  DCR_ADDR_WIDTH  entry DCR address
- cfg_wr_data  in  DCR_DATA_WIDTH  entry DCR data
- cfg_wr_rdy  out  1  table write accepted (IDLE only)
- cfg_clr  in  1  clear all entry valid bits (IDLE only, ignored otherwise)
- start_valid  in  1  launch request
- start_rdy  out  1  launch accepted
- timeout_limit  in  CNT_WIDTH  RUN timeout in cycles, 0 = disabled
- dcr_wr_valid  out  1  DCR write strobe to Vortex (registered)
- dcr_wr_addr  out  DCR_ADDR_WIDTH  DCR address (registered)
- dcr_wr_data  out  DCR_DATA_WIDTH  DCR data (registered)
- vx_busy  in  1  Vortex busy status
- done_valid  out  1  completion record valid
- done_status  out  2  0 ok, 1 timeout, 2 no-start, 3 empty table
- done_cycles  out  CNT_WIDTH  cycles counted in SETTLE+RUN
- done_rdy  in  1  completion consumed
- ctrl_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset effects:
  - state=IDLE.
  - All table valid bits, addr and data fields cleared to 0.
  - All outputs 0, except start_rdy and cfg_wr_rdy, which follow their IDLE equations.
- Reset mid-operation: abort immediately; no DCR write in the cycle after rst; no done record is produced.
- States: IDLE, WRITE, SETTLE, RUN, DONE.
- IDLE:
  - cfg_wr_rdy=1.
  - start_rdy = !vx_busy.
  - A table write sets valid[idx] and stores addr/data at the clock edge.
  - cfg_clr clears all valid bits. If cfg_clr and cfg_wr_valid occur together, the clear applies first, then the write, so only idx remains valid.
- Start acceptance at cycle T (start_valid && start_rdy):
  - If no valid entries exist after this cycle's table update: DONE at T+1, status 3, cycles 0.
  - Otherwise: WRITE at T+1, index pointer = 0.
- WRITE:
  - Exactly NUM_CFG cycles; index k is handled at cycle T+1+k in ascending order.
  - dcr_wr_valid=1 only if valid[k], carrying entry k's addr/data.
  - When dcr_wr_valid=0, addr/data hold 0.
  - Vortex has no DCR backpressure; each write is a single-cycle strobe.
  - A table write and start in the same IDLE cycle: the new value is used.
- After index NUM_CFG-1: SETTLE, with cycle_cnt cleared to 0.
- cycle_cnt: increments every cycle in SETTLE and RUN; saturates at all-ones.
- SETTLE:
  - vx_busy=1 → RUN.
  - Otherwise, when cycle_cnt reaches START_WAIT-1 → DONE, status 2.
- RUN:
  - vx_busy=0 → DONE, status 0.
  - Else if timeout_limit!=0 and cycle_cnt == timeout_limit-1 → DONE, status 1.
  - Busy falling and timeout in the same cycle: status 0 wins.
- DONE:
  - done_valid=1; done_status and done_cycles are stable until the handshake.
  - done_cycles = cycle_cnt after the final increment, i.e. total SETTLE+RUN cycles.
  - done_valid && done_rdy → IDLE next cycle; done_valid clears the same edge.
- After a timeout, Vortex may still be busy; start_rdy stays 0 until vx_busy falls.
- cfg_wr_rdy=0 and start_rdy=0 in every state other than IDLE.
- The table persists across launches; relaunch replays the same entries.

Test Plan:
- Basic launch:
  - Stimulus: load idx0=(0x01,0x8000_0000), idx2=(0x03,0x1234); start at T; vx_busy rises at T+7 and falls at T+20.
  - Required: dcr_wr_valid at T+1 (0x01) and T+3 (0x03) only; SETTLE at T+5; done status 0, cycles 16; completion held until done_rdy.
- Empty table: start with no entries → zero DCR strobes; done_valid at T+1, status 3, cycles 0.
- No start:
  - Stimulus: one entry, START_WAIT=64, vx_busy stuck low.
  - Required: done status 2, cycles 64; the next start is accepted.
- Timeout:
  - Stimulus: timeout_limit=10, vx_busy stuck high.
  - Required: done status 1, cycles 10; start_rdy=0 until vx_busy drops.
  - Tie case: busy falls on the 10th cycle → status 0.
- Same-cycle update: cfg_wr_valid(idx0, data 0xAA) with start_valid in one cycle → first DCR strobe carries 0xAA.
- Reset in WRITE: rst asserted at T+2 → no strobe at T+3; state IDLE; table cleared; no done_valid.
